attack_ctrl: RTL and testbench
==============================

// Module: attack_ctrl
// PURPOSE
//  Sequences the player's weapon attack: accepts attack/switch buttons, selects the held weapon type,
//  runs WINDUP->SWING->RECOVER->COOLDOWN per weapon, and drives the character state and type into the weapon block.
//  Sits between the keyboard decoder / player-movement FSM and the weapon block; hit_en feeds collision logic.
// PARAMETERS
//  WIND_W  2   windup ticks, wooden    | SWING_W 4  swing ticks, wooden    | COOL_W 6   cooldown ticks, wooden
//  WIND_B  3   windup ticks, basys     | SWING_B 5  swing ticks, basys     | COOL_B 10  cooldown ticks, basys
//  WIND_C  5   windup ticks, car       | SWING_C 8  swing ticks, car       | COOL_C 16  cooldown ticks, car
//  RECOV   2   recover ticks, all weapons
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous, active-low reset
//  tick       in   1  game-tick enable; all timers advance only on cycles with tick=1
//  atk_btn    in   1  one-cycle attack request pulse
//  sw_btn     in   1  one-cycle weapon-switch request pulse
//  facing     in   2  0 up, 1 down, 2 left, 3 right
//  move_state in   4  player movement state (never 4'hA-4'hD)
//  unlocked   in   3  bit i = weapon type i owned; bit0 treated as 1 always
//  stage      in   4  current stage; 4'h0 and 4'hF = no gameplay
//  state_CY   out  4  character state to weapon block
//  type       out  3  selected weapon type to weapon block
//  hit_en     out  1  damage window active
//  busy       out  1  FSM not in IDLE
//  cool_left  out  5  remaining cooldown ticks, 0 outside COOLDOWN
// BEHAVIOUR
//  Reset (rst=0 at clk edge): fsm=IDLE, type=0, timer=0, latched dir=0; outputs state_CY=move_state
//   (combinational pass), hit_en=0, busy=0, cool_left=0. Reset wins over all other inputs.
//  FSM (registered), timer loaded with N-1 on entry and decremented on tick; exit when timer==0 and tick:
//   IDLE:     atk_btn=1 -> WINDUP, latch facing and type (both frozen until IDLE).
//   WINDUP:   WIND_x ticks -> SWING.
//   SWING:    SWING_x ticks -> RECOVER.   hit_en=1 for whole state.
//   RECOVER:  RECOV ticks -> COOLDOWN.
//   COOLDOWN: COOL_x ticks -> IDLE; cool_left = timer+1.
//  atk_btn outside IDLE is ignored (no queueing). atk_btn does not need tick to start.
//  state_CY: SWING -> {up:4'hA, down:4'hB, left:4'hC, right:4'hD} from latched dir; otherwise move_state.
//  Weapon switch: sw_btn in IDLE advances type to next unlocked type cyclically 0->1->2->0, skipping
//   locked types; if none other unlocked, type unchanged. sw_btn outside IDLE ignored.
//   sw_btn and atk_btn same cycle in IDLE: attack wins, latched type = current type, no switch.
//  If type's unlocked bit clears while IDLE, type falls back to 0 on next cycle.
//  Stage gating: stage 4'h0 or 4'hF -> next cycle fsm=IDLE, timer=0, hit_en=0; buttons ignored
//   while gated; type retained. Aborting mid-SWING drops hit_en the following cycle.
//  Latency: atk_btn at cycle t -> busy=1 at t+1; state_CY attack code appears the cycle after WINDUP expires.
//  Timer width 5 bits; parameters must satisfy 1 <= value <= 31 (elaboration check).
// STRUCTURE
//  Shared package/header: state codes 4'hA-4'hD, weapon type codes (WOODEN=0, BASYS=1, CAR=2),
//   stage codes 4'h0/4'hF, FSM encoding; the same header is used by weapon and collision logic.
//  One sub-module: atk_dur_lut (combinational type,phase -> tick count) holding the parameter table.
//  Top holds FSM, timer, type-select register, output muxing.
// TESTING
//  1 rst=0 two cycles, stage=1 -> type=0, busy=0, hit_en=0, state_CY==move_state(4'h3).
//  2 tick every cycle, type 0, facing=2, atk_btn -> busy at t+1; hit_en and state_CY=4'hC for exactly
//    4 cycles starting t+3; cool_left counts 6..1; busy=0 at t+15; atk_btn during busy ignored.
//  3 unlocked=3'b101, sw_btn x3 in IDLE -> type 2,0,2; sw_btn while busy -> no change.
//  4 type 2 attack, stage forced to 4'hF mid-SWING -> hit_en=0 and busy=0 next cycle; atk_btn
//    while gated -> no start.
//  5 tick every 3rd cycle, type 1 -> SWING lasts 15 cycles; atk_btn+sw_btn same cycle -> attack
//    with type 1, type unchanged after.
//  6 rst=0 asserted mid-COOLDOWN -> all outputs at reset values next cycle; clear unlocked[2]
//    while type=2 in IDLE -> type=0 next cycle.

Source files
------------

// File: rtl/attack_ctrl_pkg.sv
// Shared definitions for the attack sequencer, the weapon block and the collision
// logic: character state codes, weapon type codes, no-gameplay stage codes, the
// FSM encoding and small helper functions.
package attack_ctrl_pkg;

    // Character state codes shown while a swing is in progress, one per direction
    localparam logic [3:0] ST_ATK_UP    = 4'hA;
    localparam logic [3:0] ST_ATK_DOWN  = 4'hB;
    localparam logic [3:0] ST_ATK_LEFT  = 4'hC;
    localparam logic [3:0] ST_ATK_RIGHT = 4'hD;

    // Facing codes
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    // Weapon type codes
    typedef logic [2:0] wpn_t;
    localparam wpn_t WPN_WOODEN = 3'd0;
    localparam wpn_t WPN_BASYS  = 3'd1;
    localparam wpn_t WPN_CAR    = 3'd2;

    // Stage values with no gameplay
    localparam logic [3:0] STAGE_OFF_LO = 4'h0;
    localparam logic [3:0] STAGE_OFF_HI = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WINDUP   = 3'd1,
        ST_SWING    = 3'd2,
        ST_RECOVER  = 3'd3,
        ST_COOLDOWN = 3'd4
    } fsm_e;

    typedef enum logic [1:0] {
        PH_WINDUP  = 2'd0,
        PH_SWING   = 2'd1,
        PH_RECOVER = 2'd2,
        PH_COOL    = 2'd3
    } phase_e;

    // Swing state code for a latched facing direction
    function automatic logic [3:0] atk_code(input logic [1:0] dir);
        logic [3:0] code;
        case (dir)
            DIR_UP:    code = ST_ATK_UP;
            DIR_DOWN:  code = ST_ATK_DOWN;
            DIR_LEFT:  code = ST_ATK_LEFT;
            DIR_RIGHT: code = ST_ATK_RIGHT;
            default:   code = ST_ATK_UP;
        endcase
        return code;
    endfunction

    // Next owned weapon in the cycle 0->1->2->0; stays put if nothing else is owned
    function automatic wpn_t next_type(input wpn_t cur, input logic [2:0] owned);
        wpn_t c1;
        wpn_t c2;
        wpn_t res;
        c1 = (cur == WPN_CAR) ? WPN_WOODEN : (cur + 3'd1);
        c2 = (c1 == WPN_CAR) ? WPN_WOODEN : (c1 + 3'd1);
        if (owned[c1[1:0]]) begin
            res = c1;
        end else if (owned[c2[1:0]]) begin
            res = c2;
        end else begin
            res = cur;
        end
        return res;
    endfunction

endpackage

// File: rtl/attack_ctrl_if.sv
// Button/status bundle between the input side (keyboard decoder, movement FSM,
// stage control) and the attack sequencer.  "type" is a reserved word, so the
// selected weapon is carried on wpn_type.
interface attack_ctrl_if;
    logic       tick;
    logic       atk_btn;
    logic       sw_btn;
    logic [1:0] facing;
    logic [3:0] move_state;
    logic [2:0] unlocked;
    logic [3:0] stage;
    logic [3:0] state_CY;
    logic [2:0] wpn_type;
    logic       hit_en;
    logic       busy;
    logic [4:0] cool_left;

    modport master (
        output tick, atk_btn, sw_btn, facing, move_state, unlocked, stage,
        input  state_CY, wpn_type, hit_en, busy, cool_left
    );

    modport slave (
        input  tick, atk_btn, sw_btn, facing, move_state, unlocked, stage,
        output state_CY, wpn_type, hit_en, busy, cool_left
    );
endinterface

// File: rtl/attack_ctrl_dur.sv
// Duration table: number of game ticks spent in a phase for a given weapon.
module atk_dur_lut
    import attack_ctrl_pkg::*;
#(
    parameter int WIND_W  = 2,
    parameter int SWING_W = 4,
    parameter int COOL_W  = 6,
    parameter int WIND_B  = 3,
    parameter int SWING_B = 5,
    parameter int COOL_B  = 10,
    parameter int WIND_C  = 5,
    parameter int SWING_C = 8,
    parameter int COOL_C  = 16,
    parameter int RECOV   = 2
) (
    input  wpn_t       wpn_type,
    input  phase_e     phase,
    output logic [4:0] ticks
);

    // A 5-bit timer loaded with N-1 needs every duration in 1..31
    if (WIND_W  < 1 || WIND_W  > 31 || SWING_W < 1 || SWING_W > 31 ||
        COOL_W  < 1 || COOL_W  > 31 || WIND_B  < 1 || WIND_B  > 31 ||
        SWING_B < 1 || SWING_B > 31 || COOL_B  < 1 || COOL_B  > 31 ||
        WIND_C  < 1 || WIND_C  > 31 || SWING_C < 1 || SWING_C > 31 ||
        COOL_C  < 1 || COOL_C  > 31 || RECOV   < 1 || RECOV   > 31) begin : g_bad_param
        $error("atk_dur_lut: every duration parameter must lie in 1..31");
    end

    // Table lookup by phase then weapon; unknown weapon codes use the wooden row
    always_comb begin
        ticks = 5'd1;
        case (phase)
            PH_WINDUP: begin
                case (wpn_type)
                    WPN_BASYS: ticks = 5'(WIND_B);
                    WPN_CAR:   ticks = 5'(WIND_C);
                    default:   ticks = 5'(WIND_W);
                endcase
            end
            PH_SWING: begin
                case (wpn_type)
                    WPN_BASYS: ticks = 5'(SWING_B);
                    WPN_CAR:   ticks = 5'(SWING_C);
                    default:   ticks = 5'(SWING_W);
                endcase
            end
            PH_RECOVER: ticks = 5'(RECOV);
            PH_COOL: begin
                case (wpn_type)
                    WPN_BASYS: ticks = 5'(COOL_B);
                    WPN_CAR:   ticks = 5'(COOL_C);
                    default:   ticks = 5'(COOL_W);
                endcase
            end
            default: ticks = 5'd1;
        endcase
    end

endmodule

// File: rtl/attack_ctrl.sv
// Attack sequencer: weapon selection in IDLE, then WINDUP->SWING->RECOVER->COOLDOWN
// timed in game ticks.  Facing and weapon are frozen for the whole attack.
module attack_ctrl
    import attack_ctrl_pkg::*;
#(
    parameter int WIND_W  = 2,
    parameter int SWING_W = 4,
    parameter int COOL_W  = 6,
    parameter int WIND_B  = 3,
    parameter int SWING_B = 5,
    parameter int COOL_B  = 10,
    parameter int WIND_C  = 5,
    parameter int SWING_C = 8,
    parameter int COOL_C  = 16,
    parameter int RECOV   = 2
) (
    input  logic          clk,
    input  logic          rst,
    attack_ctrl_if.slave  bus
);

    fsm_e       fsm_r;
    logic [4:0] timer_r;
    wpn_t       type_r;
    logic [1:0] dir_r;
    logic       hit_en_r;
    logic       busy_r;
    logic [4:0] cool_left_r;

    logic [2:0] owned_s;
    logic       gated_s;
    wpn_t       cur_type_s;
    wpn_t       lut_type_s;
    phase_e     lut_phase_s;
    logic [4:0] dur_s;

    atk_dur_lut #(
        .WIND_W (WIND_W),  .SWING_W(SWING_W), .COOL_W(COOL_W),
        .WIND_B (WIND_B),  .SWING_B(SWING_B), .COOL_B(COOL_B),
        .WIND_C (WIND_C),  .SWING_C(SWING_C), .COOL_C(COOL_C),
        .RECOV  (RECOV)
    ) u_dur (
        .wpn_type (lut_type_s),
        .phase    (lut_phase_s),
        .ticks    (dur_s)
    );

    // Ownership, stage gating, and which phase/weapon the duration table is asked about
    always_comb begin
        owned_s = bus.unlocked | 3'b001;
        gated_s = (bus.stage == STAGE_OFF_LO) || (bus.stage == STAGE_OFF_HI);
        if (owned_s[type_r[1:0]]) begin
            cur_type_s = type_r;
        end else begin
            cur_type_s = WPN_WOODEN;
        end
        if (fsm_r == ST_IDLE) begin
            lut_type_s = cur_type_s;
        end else begin
            lut_type_s = type_r;
        end
        case (fsm_r)
            ST_IDLE:    lut_phase_s = PH_WINDUP;
            ST_WINDUP:  lut_phase_s = PH_SWING;
            ST_SWING:   lut_phase_s = PH_RECOVER;
            ST_RECOVER: lut_phase_s = PH_COOL;
            default:    lut_phase_s = PH_WINDUP;
        endcase
    end

    // Attack FSM, phase timer, weapon select and registered status outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm_r       <= ST_IDLE;
            timer_r     <= 5'd0;
            type_r      <= WPN_WOODEN;
            dir_r       <= 2'd0;
            hit_en_r    <= 1'b0;
            busy_r      <= 1'b0;
            cool_left_r <= 5'd0;
        end else if (gated_s) begin
            fsm_r       <= ST_IDLE;
            timer_r     <= 5'd0;
            hit_en_r    <= 1'b0;
            busy_r      <= 1'b0;
            cool_left_r <= 5'd0;
        end else begin
            case (fsm_r)
                ST_IDLE: begin
                    if (bus.atk_btn) begin
                        fsm_r   <= ST_WINDUP;
                        timer_r <= dur_s - 5'd1;
                        dir_r   <= bus.facing;
                        type_r  <= cur_type_s;
                        busy_r  <= 1'b1;
                    end else if (bus.sw_btn) begin
                        type_r <= next_type(cur_type_s, owned_s);
                    end else begin
                        type_r <= cur_type_s;
                    end
                end
                ST_WINDUP: begin
                    if (bus.tick) begin
                        if (timer_r == 5'd0) begin
                            fsm_r    <= ST_SWING;
                            timer_r  <= dur_s - 5'd1;
                            hit_en_r <= 1'b1;
                        end else begin
                            timer_r <= timer_r - 5'd1;
                        end
                    end
                end
                ST_SWING: begin
                    if (bus.tick) begin
                        if (timer_r == 5'd0) begin
                            fsm_r    <= ST_RECOVER;
                            timer_r  <= dur_s - 5'd1;
                            hit_en_r <= 1'b0;
                        end else begin
                            timer_r <= timer_r - 5'd1;
                        end
                    end
                end
                ST_RECOVER: begin
                    if (bus.tick) begin
                        if (timer_r == 5'd0) begin
                            fsm_r       <= ST_COOLDOWN;
                            timer_r     <= dur_s - 5'd1;
                            cool_left_r <= dur_s;
                        end else begin
                            timer_r <= timer_r - 5'd1;
                        end
                    end
                end
                ST_COOLDOWN: begin
                    // cool_left tracks timer+1, so after a decrement it equals the old timer
                    if (bus.tick) begin
                        if (timer_r == 5'd0) begin
                            fsm_r       <= ST_IDLE;
                            busy_r      <= 1'b0;
                            cool_left_r <= 5'd0;
                        end else begin
                            timer_r     <= timer_r - 5'd1;
                            cool_left_r <= timer_r;
                        end
                    end
                end
                default: begin
                    fsm_r       <= ST_IDLE;
                    timer_r     <= 5'd0;
                    hit_en_r    <= 1'b0;
                    busy_r      <= 1'b0;
                    cool_left_r <= 5'd0;
                end
            endcase
        end
    end

    // Swing overrides the movement state with the directional attack code
    always_comb begin
        if (fsm_r == ST_SWING) begin
            bus.state_CY = atk_code(dir_r);
        end else begin
            bus.state_CY = bus.move_state;
        end
        bus.wpn_type  = type_r;
        bus.hit_en    = hit_en_r;
        bus.busy      = busy_r;
        bus.cool_left = cool_left_r;
    end

endmodule

// File: tb/tb_attack_ctrl.sv
// Directed bench for attack_ctrl with hand-computed expectations.
module tb_attack_ctrl;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   cyc;
    bit   tick_div3;

    attack_ctrl_if bus();

    attack_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (tick_div3) bus.tick = (cyc % 3 == 0);
    endtask

    initial begin
        int  n;
        bit  seen;
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        tick_div3 = 1'b0;

        // 1: reset
        rst            = 1'b0;
        bus.tick       = 1'b0;
        bus.atk_btn    = 1'b0;
        bus.sw_btn     = 1'b0;
        bus.facing     = 2'd2;
        bus.move_state = 4'h3;
        bus.unlocked   = 3'b001;
        bus.stage      = 4'h1;
        step();
        step();
        check_eq("t1_type", 32'(bus.wpn_type), 32'd0);
        check_eq("t1_busy", 32'(bus.busy), 32'd0);
        check_eq("t1_hit", 32'(bus.hit_en), 32'd0);
        check_eq("t1_state", 32'(bus.state_CY), 32'h3);
        check_eq("t1_cool", 32'(bus.cool_left), 32'd0);
        rst = 1'b1;
        step();

        // 2: wooden attack, tick every cycle, facing left
        bus.tick    = 1'b1;
        bus.atk_btn = 1'b1;
        step();
        bus.atk_btn = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            check_eq($sformatf("t2_busy_%0d", i), 32'(bus.busy), (i <= 14) ? 32'd1 : 32'd0);
            check_eq($sformatf("t2_hit_%0d", i), 32'(bus.hit_en), (i >= 3 && i <= 6) ? 32'd1 : 32'd0);
            check_eq($sformatf("t2_state_%0d", i), 32'(bus.state_CY), (i >= 3 && i <= 6) ? 32'hC : 32'h3);
            check_eq($sformatf("t2_cool_%0d", i), 32'(bus.cool_left),
                     (i >= 9 && i <= 14) ? 32'(15 - i) : 32'd0);
            bus.atk_btn = (i == 4);
            if (i == 2) bus.facing = 2'd3;
            step();
        end
        bus.atk_btn = 1'b0;
        check_eq("t2_noqueue", 32'(bus.busy), 32'd0);

        // 3: weapon switching with wooden+car owned
        bus.unlocked = 3'b101;
        bus.sw_btn = 1'b1; step(); bus.sw_btn = 1'b0;
        check_eq("t3_sw1", 32'(bus.wpn_type), 32'd2);
        bus.sw_btn = 1'b1; step(); bus.sw_btn = 1'b0;
        check_eq("t3_sw2", 32'(bus.wpn_type), 32'd0);
        bus.sw_btn = 1'b1; step(); bus.sw_btn = 1'b0;
        check_eq("t3_sw3", 32'(bus.wpn_type), 32'd2);

        // 4: car attack facing right, switch ignored while busy, abort mid-swing
        bus.atk_btn = 1'b1; step(); bus.atk_btn = 1'b0;
        bus.sw_btn = 1'b1; step(); bus.sw_btn = 1'b0;
        check_eq("t4_sw_busy", 32'(bus.wpn_type), 32'd2);
        check_eq("t4_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 5; i++) step();
        check_eq("t4_swing_hit", 32'(bus.hit_en), 32'd1);
        check_eq("t4_swing_state", 32'(bus.state_CY), 32'hD);
        bus.stage = 4'hF;
        step();
        check_eq("t4_abort_hit", 32'(bus.hit_en), 32'd0);
        check_eq("t4_abort_busy", 32'(bus.busy), 32'd0);
        check_eq("t4_abort_state", 32'(bus.state_CY), 32'h3);
        check_eq("t4_abort_type", 32'(bus.wpn_type), 32'd2);
        bus.atk_btn = 1'b1; step(); bus.atk_btn = 1'b0;
        check_eq("t4_gated_atk", 32'(bus.busy), 32'd0);
        bus.stage = 4'h1;
        step();
        check_eq("t4_ungated_idle", 32'(bus.busy), 32'd0);

        // 6b: losing ownership of the held weapon falls back to wooden
        bus.unlocked = 3'b001;
        step();
        check_eq("t6_fallback", 32'(bus.wpn_type), 32'd0);
        bus.unlocked = 3'b011;
        bus.sw_btn = 1'b1; step(); bus.sw_btn = 1'b0;
        check_eq("t5_sel_basys", 32'(bus.wpn_type), 32'd1);

        // 5: basys attack with tick every third cycle; attack beats switch
        tick_div3 = 1'b1;
        bus.tick  = (cyc % 3 == 0);
        bus.atk_btn = 1'b1;
        bus.sw_btn  = 1'b1;
        step();
        bus.atk_btn = 1'b0;
        bus.sw_btn  = 1'b0;
        check_eq("t5_busy", 32'(bus.busy), 32'd1);
        check_eq("t5_type_latched", 32'(bus.wpn_type), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (bus.hit_en) seen = 1'b1;
            else step();
        end
        check_eq("t5_swing_seen", 32'(seen), 32'd1);
        check_eq("t5_swing_state", 32'(bus.state_CY), 32'hD);
        n = 0;
        while (bus.hit_en && n < 100) begin
            n++;
            step();
        end
        check_eq("t5_swing_len", 32'(n), 32'd15);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (!bus.busy) seen = 1'b1;
            else step();
        end
        check_eq("t5_done", 32'(seen), 32'd1);
        check_eq("t5_type_after", 32'(bus.wpn_type), 32'd1);

        // 6a: reset in the middle of cooldown
        tick_div3 = 1'b0;
        bus.tick  = 1'b1;
        bus.atk_btn = 1'b1; step(); bus.atk_btn = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (bus.cool_left != 5'd0) seen = 1'b1;
            else step();
        end
        check_eq("t6_cool_seen", 32'(seen), 32'd1);
        check_eq("t6_cool_first", 32'(bus.cool_left), 32'd10);
        step();
        check_eq("t6_cool_next", 32'(bus.cool_left), 32'd9);
        rst = 1'b0;
        bus.move_state = 4'h5;
        step();
        check_eq("t6_rst_busy", 32'(bus.busy), 32'd0);
        check_eq("t6_rst_hit", 32'(bus.hit_en), 32'd0);
        check_eq("t6_rst_cool", 32'(bus.cool_left), 32'd0);
        check_eq("t6_rst_type", 32'(bus.wpn_type), 32'd0);
        check_eq("t6_rst_state", 32'(bus.state_CY), 32'h5);
        rst = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
